// File: rtl/lsu_bus_pkg.sv
// Shared types, constants and helpers for the LSU bus controller.
package lsu_bus_pkg;

    // Controller states: data-memory single-cycle path and peripheral handshake path
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DMEM_RSP = 3'd1,
        PER_REQ  = 3'd2,
        PER_WAIT = 3'd3,
        RESP     = 3'd4
    } lsu_state_e;

    // Response data sentinels for aborted or faulted peripheral accesses
    localparam logic [31:0] ERR_TIMEOUT = 32'hdeadbeef;
    localparam logic [31:0] ERR_BUS     = 32'hbabecafe;

    // Width of the timeout counter; large enough for TIMEOUT up to 255
    localparam int CNT_W = 8;

    // Region decode: any set bit in addr[15:8] selects the peripheral bus
    function automatic logic is_periph(input logic [31:0] addr);
        return |addr[15:8];
    endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Cycle counter that flags when a peripheral access has waited TIMEOUT cycles.
module lsu_timeout_ctr
    import lsu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Value held by the counter during the last permitted waiting cycle
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count while enabled and hold at the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is reported in the TIMEOUT-th enabled cycle after a clear
    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/lsu_bus_ctrl.sv
// LSU bus controller: routes one load/store at a time to data memory or the
// peripheral bus and returns a single-cycle response to the LSU.
module lsu_bus_ctrl
    import lsu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    // LSU request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    // LSU response
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // Data memory
    output logic        dmem_en,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    // Peripheral bus
    output logic        per_req,
    input  logic        per_gnt,
    output logic        per_we,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    output logic [3:0]  per_be,
    input  logic        per_rvalid,
    input  logic [31:0] per_rdata,
    input  logic        per_err
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        ctr_clear_s;
    logic        ctr_en_s;
    logic        expired_s;
    logic [31:0] per_data_s;

    lsu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (ctr_clear_s),
        .enable_i  (ctr_en_s),
        .expired_o (expired_s)
    );

    // Data memory sees the live request; only the enable is gated by the FSM
    assign dmem_we    = req_we;
    assign dmem_addr  = req_addr;
    assign dmem_wdata = req_wdata;
    assign dmem_be    = req_be;

    // Peripheral fields come from the copy latched at accept
    assign per_we     = we_q;
    assign per_addr   = addr_q;
    assign per_wdata  = wdata_q;
    assign per_be     = be_q;

    // Data returned on a peripheral response: bus error sentinel, zero for writes
    assign per_data_s = per_err ? ERR_BUS : (we_q ? 32'h0000_0000 : per_rdata);

    // Next-state, latch enables and LSU/bus handshake outputs
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        ctr_clear_s = 1'b0;
        ctr_en_s    = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = 32'h0000_0000;
        rsp_err     = 1'b0;
        dmem_en     = 1'b0;
        per_req     = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (is_periph(req_addr)) begin
                        ctr_clear_s = 1'b1;
                        state_d     = PER_REQ;
                    end else begin
                        dmem_en = 1'b1;
                        state_d = DMEM_RSP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            DMEM_RSP: begin
                rsp_valid = 1'b1;
                rsp_rdata = we_q ? 32'h0000_0000 : dmem_rdata;
                state_d   = IDLE;
            end

            PER_REQ: begin
                per_req  = 1'b1;
                ctr_en_s = 1'b1;
                if (per_gnt && per_rvalid) begin
                    rdata_d = per_data_s;
                    err_d   = per_err;
                    state_d = RESP;
                end else if (expired_s) begin
                    rdata_d = ERR_TIMEOUT;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (per_gnt) begin
                    state_d = PER_WAIT;
                end else begin
                    state_d = PER_REQ;
                end
            end

            PER_WAIT: begin
                ctr_en_s = 1'b1;
                if (per_rvalid) begin
                    rdata_d = per_data_s;
                    err_d   = per_err;
                    state_d = RESP;
                end else if (expired_s) begin
                    rdata_d = ERR_TIMEOUT;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = PER_WAIT;
                end
            end

            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched request/response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            be_q    <= 4'h0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed vector tables, a reset
// corner case and randomized transactions against a cycle-count model.
module tb_lsu_bus_ctrl;

    localparam int TMO   = 16;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        dmem_en, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        per_req, per_gnt, per_we, per_rvalid, per_err;
    logic [31:0] per_addr, per_wdata, per_rdata;
    logic [3:0]  per_be;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_bus_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .per_req(per_req), .per_gnt(per_gnt), .per_we(per_we),
        .per_addr(per_addr), .per_wdata(per_wdata), .per_be(per_be),
        .per_rvalid(per_rvalid), .per_rdata(per_rdata), .per_err(per_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mrd;
        logic [31:0] exp_rd;
    } dvec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          g;
        int          r;
        logic        err;
        logic [31:0] prd;
        int          lat;
        logic [31:0] exp_rd;
        logic        exp_err;
    } pvec_t;

    dvec_t dtab[4];
    pvec_t ptab[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of a peripheral access from the handshake timing rules:
    // the response appears the cycle after the honoured rvalid, or after the
    // TMO-th waiting cycle when no rvalid arrives in time.
    function automatic void per_model(input int g, input int r, input logic we, input logic err,
                                      input logic [31:0] prd, output int lat,
                                      output logic [31:0] data, output logic eflag);
        int rv_c;
        rv_c = (g >= 0 && r >= 0) ? 1 + g + r : NEVER;
        if (rv_c <= TMO) begin
            lat   = rv_c + 1;
            eflag = err;
            data  = err ? 32'hbabecafe : (we ? 32'h0 : prd);
        end else begin
            lat   = TMO + 1;
            eflag = 1'b1;
            data  = 32'hdeadbeef;
        end
    endfunction

    task automatic dmem_run(input dvec_t v);
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
        dmem_rdata = $urandom;
        #1;
        chk1("dm_ready", req_ready, 1'b1);
        chk1("dm_en", dmem_en, 1'b1);
        chk1("dm_we", dmem_we, v.we);
        chk("dm_addr", dmem_addr, v.addr);
        chk("dm_wdata", dmem_wdata, v.wdata);
        chk("dm_be", {28'h0, dmem_be}, {28'h0, v.be});
        chk1("dm_no_perreq", per_req, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; dmem_rdata = v.mrd;
        #1;
        chk1("dm_rsp_valid", rsp_valid, 1'b1);
        chk("dm_rsp_rdata", rsp_rdata, v.exp_rd);
        chk1("dm_rsp_err", rsp_err, 1'b0);
        chk1("dm_en_off", dmem_en, 1'b0);
        @(negedge clk);
        #1;
        chk1("dm_rsp_once", rsp_valid, 1'b0);
        chk1("dm_ready_back", req_ready, 1'b1);
    endtask

    task automatic per_run(input pvec_t v);
        int gnt_c, rv_c, req_end, last_c;
        gnt_c   = (v.g >= 0) ? 1 + v.g : NEVER;
        rv_c    = (v.g >= 0 && v.r >= 0) ? 1 + v.g + v.r : NEVER;
        req_end = (gnt_c < v.lat - 1) ? gnt_c : v.lat - 1;
        last_c  = v.lat + 1;
        if (rv_c != NEVER && rv_c + 1 > last_c) last_c = rv_c + 1;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
        per_gnt = 1'b0; per_rvalid = 1'b0;
        #1;
        chk1("pr_accept_ready", req_ready, 1'b1);
        chk1("pr_no_dmem", dmem_en, 1'b0);
        chk1("pr_req_not_yet", per_req, 1'b0);
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            req_valid = 1'b0; req_we = ~v.we; req_addr = $urandom; req_wdata = $urandom;
            per_gnt = (c == gnt_c); per_rvalid = (c == rv_c);
            per_err = v.err; per_rdata = v.prd;
            #1;
            chk1("pr_req", per_req, c <= req_end);
            if (c <= req_end) begin
                chk1("pr_we", per_we, v.we);
                chk("pr_addr", per_addr, v.addr);
                chk("pr_wdata", per_wdata, v.wdata);
                chk("pr_be", {28'h0, per_be}, {28'h0, v.be});
            end
            chk1("pr_rsp_valid", rsp_valid, c == v.lat);
            if (c == v.lat) begin
                chk("pr_rsp_rdata", rsp_rdata, v.exp_rd);
                chk1("pr_rsp_err", rsp_err, v.exp_err);
            end
            chk1("pr_ready", req_ready, c > v.lat);
            chk1("pr_dmem_quiet", dmem_en, 1'b0);
        end
        per_gnt = 1'b0; per_rvalid = 1'b0; per_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dtab[0] = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 32'h1234_5678, 32'h1234_5678};
        dtab[1] = '{1'b1, 32'h0000_00FC, 32'h5A5A_0001, 4'h3, 32'hFFFF_FFFF, 32'h0};
        dtab[2] = '{1'b0, 32'hFFFF_00FF, 32'h0,         4'h1, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        dtab[3] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0000_0000, 32'h0};

        ptab[0] = '{1'b1, 32'h0000_0100, 32'hCAFE_0001, 4'hF, 2, 1,  1'b0, 32'h1111_1111, 5,  32'h0,         1'b0};
        ptab[1] = '{1'b0, 32'h0000_8000, 32'h0,         4'hF, 0, 1,  1'b1, 32'h1212_1212, 3,  32'hbabecafe,  1'b1};
        ptab[2] = '{1'b0, 32'h0000_0200, 32'h0,         4'hF, 0, 20, 1'b0, 32'h7777_7777, 17, 32'hdeadbeef,  1'b1};
        ptab[3] = '{1'b0, 32'h0000_0F00, 32'h0,         4'h3, 3, 12, 1'b0, 32'h5555_AAAA, 17, 32'h5555_AAAA,  1'b0};
        ptab[4] = '{1'b0, 32'h1234_0800, 32'h0,         4'hF, 3, 13, 1'b0, 32'h5555_AAAA, 17, 32'hdeadbeef,  1'b1};
        ptab[5] = '{1'b0, 32'h0000_FF00, 32'h0,         4'hC, 0, 0,  1'b0, 32'h0BAD_F00D, 2,  32'h0BAD_F00D,  1'b0};
        ptab[6] = '{1'b1, 32'h0000_0400, 32'h1357_9BDF, 4'hF, -1, -1, 1'b0, 32'h0,        17, 32'hdeadbeef,  1'b1};
        ptab[7] = '{1'b1, 32'h0000_0104, 32'h2468_ACE0, 4'h8, 1, 2,  1'b1, 32'h9999_9999, 5,  32'hbabecafe,  1'b1};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
        dmem_rdata = 32'h0; per_gnt = 1'b0; per_rvalid = 1'b0; per_rdata = 32'h0; per_err = 1'b0;

        #13;
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk1("rst_dmem_en", dmem_en, 1'b0);
        chk1("rst_per_req", per_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) dmem_run(dtab[i]);
        for (int i = 0; i < 8; i++) per_run(ptab[i]);

        // Reset while waiting for a peripheral response: drop it, ignore late rvalid
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0300; req_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b0; per_gnt = 1'b1;
        #1;
        chk1("rw_req_in_grant", per_req, 1'b1);
        @(negedge clk);
        per_gnt = 1'b0;
        #1;
        chk1("rw_busy", req_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk1("rw_per_req", per_req, 1'b0);
        chk1("rw_ready", req_ready, 1'b1);
        chk1("rw_no_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0; per_rvalid = 1'b1; per_rdata = 32'h4242_4242;
        #1;
        chk1("rw_late_rvalid", rsp_valid, 1'b0);
        @(negedge clk);
        per_rvalid = 1'b0;
        #1;
        chk1("rw_still_quiet", rsp_valid, 1'b0);
        chk1("rw_idle", req_ready, 1'b1);
        chk1("rw_idle_per_req", per_req, 1'b0);

        // Randomized mix of data-memory and peripheral accesses
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                dvec_t d;
                d.we    = 1'($urandom_range(0, 1));
                d.addr  = $urandom & 32'hFFFF_00FF;
                d.wdata = $urandom;
                d.be    = 4'($urandom_range(0, 15));
                d.mrd   = $urandom;
                d.exp_rd = d.we ? 32'h0 : d.mrd;
                dmem_run(d);
            end else begin
                pvec_t p;
                p.we    = 1'($urandom_range(0, 1));
                p.addr  = $urandom;
                if (p.addr[15:8] == 8'h00) p.addr[8] = 1'b1;
                p.wdata = $urandom;
                p.be    = 4'($urandom_range(0, 15));
                p.g     = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8));
                p.r     = int'($urandom_range(0, 12));
                p.err   = ($urandom_range(0, 3) == 0);
                p.prd   = $urandom;
                per_model(p.g, p.r, p.we, p.err, p.prd, p.lat, p.exp_rd, p.exp_err);
                per_run(p);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles from peripheral-request accept to response before abort (range 2..255).
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have LSU request ports: req_valid in 1; req_ready out 1; req_we in 1; req_addr in 32; req_wdata in 32; req_be in 4.
REQ-005 SHALL have LSU response ports: rsp_valid out 1; rsp_rdata out 32; rsp_err out 1 (error flag).
REQ-006 SHALL have data-memory ports: dmem_en out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_be out 4; dmem_rdata in 32 (valid 1 cycle after dmem_en).
REQ-007 SHALL have peripheral ports: per_req out 1; per_gnt in 1; per_we out 1; per_addr out 32; per_wdata out 32; per_be out 4; per_rvalid in 1; per_rdata in 32; per_err in 1.

Function
REQ-008 Region decode SHALL be: peripheral if any of req_addr[15:8] is 1, else data memory.
REQ-009 FSM states SHALL be IDLE, DMEM_RSP, PER_REQ, PER_WAIT, RESP.
REQ-010 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready.
REQ-011 Data access accepted in cycle N: dmem_en=1 and dmem_we/addr/wdata/be driven combinationally from the request in cycle N; next state DMEM_RSP.
REQ-012 In DMEM_RSP (cycle N+1): rsp_valid=1, rsp_err=0, rsp_rdata=dmem_rdata for reads and 32'h0 for writes; next state IDLE.
REQ-013 Peripheral access accepted: addr/wdata/we/be SHALL be latched; timeout counter cleared; next state PER_REQ.
REQ-014 In PER_REQ: per_req=1 with latched fields; per_gnt=1 moves to PER_WAIT; per_req SHALL stay high until the grant cycle inclusive.
REQ-015 per_rvalid SHALL be honoured in PER_WAIT and also in PER_REQ in the same cycle as per_gnt; per_rvalid outside these is ignored.
REQ-016 On honoured per_rvalid: latch rsp_rdata = per_err ? 32'hbabecafe : per_rdata (32'h0 for writes without error), rsp_err = per_err; go RESP.
REQ-017 The timeout counter SHALL increment each cycle in PER_REQ/PER_WAIT; on reaching TIMEOUT with no honoured per_rvalid, per_req drops, rsp_rdata=32'hdeadbeef, rsp_err=1, go RESP.
REQ-018 per_rvalid in the same cycle as timeout expiry SHALL win (normal response).
REQ-019 RESP SHALL assert rsp_valid for exactly one cycle, then go IDLE; peripheral latency from accept to rsp_valid is at least 2 cycles.
REQ-020 dmem_en and per_req SHALL never both be 1; at most one access in flight.

Reset
REQ-021 rst SHALL force IDLE immediately: req_ready=1; rsp_valid, rsp_err, rsp_rdata, dmem_en, per_req, counter all 0.
REQ-022 An access in flight at reset SHALL be dropped without a response; per_rvalid arriving after reset is ignored.

Structure
REQ-023 Package lsu_bus_pkg SHALL hold the FSM state enum, the sentinels ERR_TIMEOUT=32'hdeadbeef and ERR_BUS=32'hbabecafe, and the region-decode function.
REQ-024 The timeout counter SHALL be sub-module lsu_timeout_ctr (clear, enable, expired output, TIMEOUT parameter).

Verification
REQ-025 Read addr 0x0000_0040, dmem_rdata=0x1234_5678 -> dmem_en in accept cycle, rsp_valid next cycle, rdata 0x12345678, err 0.
REQ-026 Write addr 0x0000_0100 wdata 0xCAFE_0001, per_gnt after 2 cycles, per_rvalid 1 cycle later -> per_we=1, rsp_rdata 0, err 0.
REQ-027 Peripheral read, per_rvalid with per_err=1 -> rsp_rdata 0xbabecafe, rsp_err 1.
REQ-028 Peripheral read, no per_rvalid, TIMEOUT=16 -> rsp_valid 17 cycles after accept, rdata 0xdeadbeef, err 1; later stray per_rvalid ignored.
REQ-029 per_rvalid on the expiry cycle -> normal rdata returned, err 0.
REQ-030 rst asserted during PER_WAIT -> per_req 0 and req_ready 1 immediately, no rsp_valid.
